fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 15, meaning tap count (legal range 2..16).
REQ-002 The block SHALL have port clock  input  1  the single system clock; all logic SHALL be rising-edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port sample_valid  input  1  one-cycle strobe marking a new input_sample.
REQ-005 The block SHALL have port input_sample  input  16  signed two's-complement sample.
REQ-006 The block SHALL have port coef_we  input  1  coefficient write enable.
REQ-007 The block SHALL have port coef_addr  input  4  coefficient index.
REQ-008 The block SHALL have port coef_data  input  16  signed Q1.15 coefficient.
REQ-009 The block SHALL have port output_sample  output  16  signed filtered sample, held between updates.
REQ-010 The block SHALL have port output_valid  output  1  one-cycle strobe marking an output_sample update.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port overrun  output  1  sticky flag for dropped samples.

Function
REQ-013 The block SHALL compute y = sum over k=0..N-1 of c[k]*x[n-k] using exactly one 16x16 signed multiplier, time-shared across all taps.
REQ-014 The FSM SHALL have states IDLE, SHIFT, MAC, and OUT.
- IDLE->SHIFT on sample_valid.
- SHIFT->MAC after 1 cycle.
- MAC->OUT after N cycles.
- OUT->IDLE after 1 cycle.
REQ-015 SHIFT SHALL move delay line x[k] <= x[k-1] for k=N-1..1, load x[0] <= input_sample, and clear the accumulator.
REQ-016 MAC cycle i (i=0..N-1) SHALL add the sign-extended 32-bit product c[i]*x[i] into a 36-bit signed accumulator.
REQ-017 OUT SHALL load output_sample with accumulator bits [30:15] (arithmetic shift right 15, floor), subject to REQ-027, and pulse output_valid.
REQ-018 Latency SHALL be fixed: sample_valid at cycle t gives output_valid at cycle t+N+2; back-to-back sample spacing SHALL be at least N+3 cycles.
REQ-019 A sample_valid while busy=1 SHALL be dropped (no state change) and SHALL set overrun; overrun SHALL clear only on reset.
REQ-020 coef_we in IDLE SHALL write c[coef_addr] <= coef_data in that cycle.
- coef_we while busy SHALL be ignored.
- coef_addr >= N SHALL be ignored.
REQ-021 Simultaneous coef_we and sample_valid in IDLE SHALL perform both; the new coefficient SHALL be used for that sample.
REQ-022 output_sample SHALL hold its value in all states except OUT.

Reset
REQ-023 Reset SHALL force state IDLE, clear all delay-line registers, all coefficients and the accumulator to 0, and drive output_sample=0, output_valid=0, busy=0 and overrun=0.
REQ-024 Reset asserted mid-operation SHALL abort the computation with no output_valid pulse, and reset takes priority over every other input.
REQ-025 The first sample_valid accepted after reset deassertion SHALL be the cycle following deassertion at the earliest.

Configuration
REQ-026 The macro FIR_SAT_EN SHALL select the output conversion.
REQ-027 With FIR_SAT_EN defined, OUT SHALL saturate accumulator>>>15 to [-32768, 32767].
REQ-028 Without FIR_SAT_EN, OUT SHALL truncate to bits [30:15] (wrap-around), and the saturation logic SHALL be absent.

Verification
REQ-029 Impulse test: set c[7]=16389 and all other coefficients 0, then send input 32767 followed by 14 zeros. The bench SHALL see output_valid after each sample, output 0 for samples 0..6, and output 16388 at sample 7.
REQ-030 Gain test: set c[0]=16384, send input 1000 -> output_sample=500 exactly 17 cycles after sample_valid.
REQ-031 Saturation test: set all c[k]=32767 and send 15 samples of 32767.
- With FIR_SAT_EN, the final output SHALL be 32767.
- With -32768 inputs, the final output SHALL be -32768.
- Without FIR_SAT_EN, the final output SHALL equal bits [30:15] of 491490*32768.
REQ-032 Overrun test: send a second sample_valid 5 cycles after the first -> the second sample is dropped, overrun=1, exactly one output_valid occurs, and the delay line holds one new sample.
REQ-033 Coefficient-while-busy test: coef_we with c[0]=100 during MAC SHALL leave c[0] unchanged, confirmed by the next sample's output; a write in the same cycle as sample_valid in IDLE SHALL take effect.
REQ-034 Reset-mid-MAC test: assert reset at MAC cycle 3 -> no output_valid pulse, output_sample=0, and a following impulse SHALL give outputs as in REQ-029.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : N-tap FIR filter that time-shares one 16x16 signed multiplier
//               across all taps (IDLE -> SHIFT -> MAC x N -> OUT).
//               Define FIR_SAT_EN to saturate the output; otherwise it wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int N = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] input_sample,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [15:0] coef_data,
    output logic [15:0] output_sample,
    output logic        output_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [3:0] c_TAP_LAST = 4'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic signed [15:0] r_delay [0:N-1];
    logic signed [15:0] r_coef  [0:N-1];
    logic signed [15:0] r_sample_hold;
    logic signed [35:0] r_acc;
    logic        [3:0]  r_tap_idx;
    logic        [15:0] r_out_sample;
    logic               r_out_valid;
    logic               r_overrun;

    logic signed [15:0] w_mac_coef;
    logic signed [15:0] w_mac_data;
    logic signed [31:0] w_product;
    logic signed [35:0] w_product_ext;
    logic               w_tap_last;
    logic        [15:0] w_out_conv;

    // Single shared multiplier; the tap index selects its operands.
    assign w_mac_coef    = r_coef[r_tap_idx];
    assign w_mac_data    = r_delay[r_tap_idx];
    assign w_product     = w_mac_coef * w_mac_data;
    assign w_product_ext = {{4{w_product[31]}}, w_product};
    assign w_tap_last    = (r_tap_idx == c_TAP_LAST);

`ifdef FIR_SAT_EN
    logic w_acc_ovf;
    logic w_unused_acc_bits;

    // acc>>>15 fits in 16 bits only when bits [35:30] are all equal.
    assign w_acc_ovf = !((&r_acc[35:30]) || !(|r_acc[35:30]));

    always_comb begin
        w_out_conv = r_acc[30:15];
        if (w_acc_ovf) begin
            w_out_conv = r_acc[35] ? 16'h8000 : 16'h7FFF;
        end
    end

    assign w_unused_acc_bits = ^r_acc[14:0];
`else
    logic w_unused_acc_bits;

    assign w_out_conv        = r_acc[30:15];
    assign w_unused_acc_bits = ^{r_acc[35:31], r_acc[14:0]};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (sample_valid) w_state_next = SHIFT;
            SHIFT:   w_state_next = MAC;
            MAC:     if (w_tap_last) w_state_next = OUT;
            OUT:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                r_delay[k] <= '0;
                r_coef[k]  <= '0;
            end
            r_sample_hold <= '0;
            r_acc         <= '0;
            r_tap_idx     <= '0;
            r_out_sample  <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (coef_we && (coef_addr <= c_TAP_LAST)) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                    // The strobe is one cycle wide, so hold the sample for SHIFT.
                    if (sample_valid) begin
                        r_sample_hold <= input_sample;
                    end
                end
                SHIFT: begin
                    for (int k = N - 1; k > 0; k--) begin
                        r_delay[k] <= r_delay[k-1];
                    end
                    r_delay[0] <= r_sample_hold;
                    r_acc      <= '0;
                    r_tap_idx  <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + w_product_ext;
                    if (!w_tap_last) begin
                        r_tap_idx <= r_tap_idx + 4'd1;
                    end
                end
                OUT: begin
                    r_out_sample <= w_out_conv;
                    r_out_valid  <= 1'b1;
                end
                default: ;
            endcase
            if (sample_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign output_sample = r_out_sample;
    assign output_valid  = r_out_valid;
    assign busy          = (r_state != IDLE);
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Scoreboard bench for fir_mac_sequencer with a behavioural
//               FIR model; honours FIR_SAT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int N = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] input_sample = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic [15:0] output_sample;
    logic        output_valid;
    logic        busy;
    logic        overrun;

    fir_mac_sequencer #(.N(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .input_sample  (input_sample),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .output_sample (output_sample),
        .output_valid  (output_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          x_m[N];
    int          c_m[N];
    int          last_acc = -1000;
    bit          ovr_m    = 1'b0;
    logic [15:0] hold_m   = '0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] conv(input longint acc);
        longint y;
        y = acc >>> 15;
`ifdef FIR_SAT_EN
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
`endif
        return y[15:0];
    endfunction

    // Monitor: pops the scoreboard on every output strobe, checks flags each cycle.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (output_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got output_valid=1 at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("output_sample", {16'd0, output_sample}, {16'd0, e.val});
                    check("output_latency", cyc, e.due);
                    hold_m = e.val;
                end
            end else begin
                check("output_hold", {16'd0, output_sample}, {16'd0, hold_m});
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_output: got no output_valid by cycle %0d, required at %0d", cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end
            check("busy", {31'd0, busy}, {31'd0, (cyc >= last_acc && cyc <= last_acc + N + 1)});
            check("overrun", {31'd0, overrun}, {31'd0, ovr_m});
        end
    end

    task automatic do_reset();
        mon_en       = 1'b0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            x_m[k] = 0;
            c_m[k] = 0;
        end
        ovr_m    = 1'b0;
        hold_m   = '0;
        last_acc = -1000;
        check("reset_output_sample", {16'd0, output_sample}, 32'd0);
        check("reset_output_valid", {31'd0, output_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    // One clock of stimulus; the model is updated from what the edge sampled.
    task automatic step(input bit sv, input logic [15:0] s, input bit we,
                        input logic [3:0] a, input logic [15:0] d);
        int     e;
        bit     busy_m;
        longint acc;
        sample_valid = sv;
        input_sample = s;
        coef_we      = we;
        coef_addr    = a;
        coef_data    = d;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        e      = cyc;
        busy_m = (e >= last_acc + 1) && (e <= last_acc + N + 2);
        if (we && !busy_m && int'(a) < N) c_m[a] = int'($signed(d));
        if (sv) begin
            if (busy_m) begin
                ovr_m = 1'b1;
            end else begin
                for (int k = N - 1; k > 0; k--) x_m[k] = x_m[k-1];
                x_m[0] = int'($signed(s));
                acc = 0;
                for (int k = 0; k < N; k++) acc += longint'(c_m[k]) * longint'(x_m[k]);
                exp_q.push_back('{val: conv(acc), due: e + N + 2});
                last_acc = e;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        step(1'b0, '0, 1'b1, a, d);
    endtask

    task automatic send(input logic [15:0] s);
        step(1'b1, s, 1'b0, '0, '0);
        idle(N + 2);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
        end
        idle(3);
    endtask

    initial begin
        // Impulse response through tap 7.
        do_reset();
        write_coef(4'd7, 16'd16389);
        send(16'd32767);
        check("impulse_s0", {16'd0, output_sample}, 32'd0);
        for (int i = 1; i < 15; i++) begin
            send(16'd0);
            if (i == 7) check("impulse_tap7", {16'd0, output_sample}, 32'd16388);
            else if (i < 7) check("impulse_zero", {16'd0, output_sample}, 32'd0);
        end
        drain();

        // Half gain on tap 0.
        do_reset();
        write_coef(4'd0, 16'd16384);
        send(16'd1000);
        check("gain_500", {16'd0, output_sample}, 32'd500);
        drain();

        // Coefficient writes while busy are ignored; same-cycle IDLE write applies.
        do_reset();
        write_coef(4'd0, 16'd16384);
        step(1'b1, 16'd1000, 1'b0, '0, '0);
        idle(5);
        write_coef(4'd0, 16'd100);
        drain();
        send(16'd1000);
        check("coef_busy_ignored", {16'd0, output_sample}, 32'd500);
        step(1'b1, 16'd2000, 1'b1, 4'd0, 16'd100);
        idle(N + 2);
        check("coef_same_cycle", {16'd0, output_sample}, 32'd6);
        write_coef(4'd15, 16'h1234);
        drain();

        // Saturation / wrap with full-scale positive then negative inputs.
        do_reset();
        for (int k = 0; k < N; k++) write_coef(4'(k), 16'd32767);
        for (int i = 0; i < 15; i++) send(16'd32767);
`ifdef FIR_SAT_EN
        check("sat_pos", {16'd0, output_sample}, 32'h7FFF);
`else
        check("wrap_pos", {16'd0, output_sample}, 32'd32738);
`endif
        for (int i = 0; i < 15; i++) send(16'h8000);
`ifdef FIR_SAT_EN
        check("sat_neg", {16'd0, output_sample}, 32'h8000);
`else
        check("wrap_neg", {16'd0, output_sample}, 32'h800F);
`endif
        drain();

        // Overrun: second strobe five cycles later is dropped.
        do_reset();
        write_coef(4'd0, 16'd16384);
        write_coef(4'd1, 16'd8192);
        step(1'b1, 16'd100, 1'b0, '0, '0);
        idle(4);
        step(1'b1, 16'd200, 1'b0, '0, '0);
        drain();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        send(16'd300);
        check("overrun_delay_line", {16'd0, output_sample}, 32'd175);
        drain();

        // Reset during MAC cycle 3 aborts, then the impulse still works.
        do_reset();
        write_coef(4'd0, 16'd16384);
        step(1'b1, 16'd1000, 1'b0, '0, '0);
        idle(4);
        do_reset();
        check("abort_output_zero", {16'd0, output_sample}, 32'd0);
        write_coef(4'd7, 16'd16389);
        send(16'd32767);
        for (int i = 1; i < 15; i++) begin
            send(16'd0);
            if (i == 7) check("post_reset_tap7", {16'd0, output_sample}, 32'd16388);
        end
        drain();

        // Randomized traffic, including overruns and out-of-range addresses.
        do_reset();
        for (int it = 0; it < 250; it++) begin
            logic [15:0] s;
            s = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            if ($urandom_range(0, 9) < 3) begin
                write_coef(4'($urandom_range(0, 15)), 16'($urandom));
            end else begin
                step(1'b1, s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
            end
            idle($urandom_range(0, N + 4));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
